dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter TIMEOUT, default 16, max RAM wait cycles before error response.
REQ-002 CLK  input  1  system clock, all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 dREN  input  1  data read request, held until dhit.
REQ-005 dWEN  input  1  data write request, held until dhit.
REQ-006 datomic  input  1  request is LL (with dREN) or SC (with dWEN).
REQ-007 daddr  input  32  byte address; bits [1:0] ignored.
REQ-008 dstore  input  32  write data.
REQ-009 dhit  output  1  single-cycle completion pulse.
REQ-010 dload  output  32  read data, or SC result; valid only while dhit=1.
REQ-011 derr  output  1  with dhit, marks a timed-out or RAM-error access.
REQ-012 ramREN / ramWEN  output  1 each  backing RAM enables.
REQ-013 ramaddr  output  32  RAM address, {daddr[31:2],2'b00}.
REQ-014 ramstore  output  32  RAM write data.
REQ-015 ramload  input  32  RAM read data.
REQ-016 ramstate  input  ramstate_t  FREE/BUSY/ACCESS/ERROR from RAM.
REQ-017 snoopwen  input  1  another master wrote snoopaddr this cycle.
REQ-018 snoopaddr  input  32  address of external write.

Function
REQ-019 FSM states: IDLE, ACCESS, RESP, SCFAIL.
REQ-020 IDLE: dWEN=1 (priority over dREN) or dREN=1 -> latch addr/data/type, go ACCESS; SC with no valid matching link -> go SCFAIL instead.
REQ-021 ACCESS: ramREN or ramWEN held high with latched addr/data; wait counter increments each cycle.
REQ-022 ACCESS exit: ramstate=ACCESS -> RESP, derr=0; ramstate=ERROR or counter reaches TIMEOUT -> RESP, derr=1, no link update.
REQ-023 RESP: dhit=1 for exactly one cycle; dload=captured ramload (read), 32'd1 (successful SC), 32'd0 (plain write); then IDLE.
REQ-024 SCFAIL: dhit=1, dload=32'd0, no RAM enables; then IDLE; minimum latency 2 cycles from request.
REQ-025 Minimum read/write latency: request cycle + ACCESS (>=1) + RESP; dhit never asserted outside RESP/SCFAIL.
REQ-026 After any dhit the block spends one cycle in IDLE before sampling a new request.
REQ-027 Link register: valid bit + 30-bit word address; LL completing without error sets valid and loads daddr[31:2].
REQ-028 Link cleared on: successful SC; any completed write (this port) to linked word; snoopwen with matching snoopaddr[31:2]; reset.
REQ-029 Snoop clear has priority over a same-cycle LL set of the same word (link ends invalid).
REQ-030 SC whose snoop invalidation arrives while in ACCESS still completes the RAM write (decision taken at IDLE).
REQ-031 Failed SC (any path) never asserts ramWEN.

Reset
REQ-032 RST=1 on a clock edge: state IDLE, counter 0, link invalid, latched data 0.
REQ-033 While in reset and the cycle after: dhit=0, derr=0, dload=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
REQ-034 Reset mid-ACCESS abandons the access; no dhit is issued for it.

Structure
REQ-035 ramstate_t and word_t come from cpu_types_pkg; FSM state enum and link-register struct added there.
REQ-036 Single module; no sub-modules; link register is a separate always_ff block.

Verification
REQ-037 LW 0x100, RAM returns ACCESS after 3 cycles with 0xDEADBEEF -> dhit one cycle later, dload=0xDEADBEEF, derr=0.
REQ-038 LL 0x200 then SC 0x200 dstore=0x5 -> ramWEN with 0x5, dload=1; repeat SC -> SCFAIL, dload=0, no ramWEN.
REQ-039 LL 0x200, snoopwen snoopaddr=0x203, SC 0x200 -> dload=0, no RAM write.
REQ-040 LL 0x200, SW 0x200, SC 0x200 -> SC fails; LL 0x200, SW 0x204, SC 0x200 -> SC succeeds.
REQ-041 LW with ramstate held BUSY -> after TIMEOUT cycles dhit=1, derr=1; ramstate=ERROR -> same next cycle.
REQ-042 RST asserted during ACCESS -> ramREN drops next cycle, no dhit, link invalid; dREN+dWEN together -> write performed.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake state, data word, and the data-port
// responder's FSM state and load-link register.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

  typedef enum logic [1:0] {StIdle, StAccess, StResp, StScFail} dstate_t;

  typedef struct packed {
    logic        valid;
    logic [29:0] addr;
  } link_t;

endpackage

// File: rtl/dmem_responder.sv
// Data-memory port responder: turns held dREN/dWEN requests into a RAM access
// with timeout, and tracks one LL/SC reservation invalidated by local or snooped writes.
module dmem_responder
  import cpu_types_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      dREN,
  input  logic      dWEN,
  input  logic      datomic,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dhit,
  output word_t     dload,
  output logic      derr,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  input  logic      snoopwen,
  input  word_t     snoopaddr
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  dstate_t         state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [29:0]     addr_q, addr_d;
  word_t           data_q, data_d;
  word_t           load_q, load_d;
  logic            write_q, write_d;
  logic            atomic_q, atomic_d;
  logic            err_q, err_d;
  link_t           link_q, link_d;
  logic            link_hit;

  // Byte-offset bits carry no meaning for word accesses.
  logic unused_byte_bits;
  assign unused_byte_bits = ^{daddr[1:0], snoopaddr[1:0]};

  // A snoop to the SC's word in the request cycle already kills the reservation.
  assign link_hit = link_q.valid && (link_q.addr == daddr[31:2]) &&
                    !(snoopwen && (snoopaddr[31:2] == daddr[31:2]));

  assign ramaddr  = {addr_q, 2'b00};
  assign ramstore = data_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    load_d   = load_q;
    write_d  = write_q;
    atomic_d = atomic_q;
    err_d    = err_q;
    dhit     = 1'b0;
    dload    = '0;
    derr     = 1'b0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (dWEN || dREN) begin
          addr_d   = daddr[31:2];
          data_d   = dstore;
          write_d  = dWEN;
          atomic_d = datomic;
          cnt_d    = '0;
          err_d    = 1'b0;
          load_d   = '0;
          state_d  = (dWEN && datomic && !link_hit) ? StScFail : StAccess;
        end
      end
      StAccess: begin
        ramREN = !write_q;
        ramWEN = write_q;
        cnt_d  = cnt_q + 1'b1;
        if (ramstate == ACCESS) begin
          load_d  = write_q ? (atomic_q ? 32'd1 : 32'd0) : ramload;
          err_d   = 1'b0;
          state_d = StResp;
        end else if ((ramstate == ERROR) || (cnt_q == CntW'(TIMEOUT - 1))) begin
          load_d  = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        dhit    = 1'b1;
        dload   = load_q;
        derr    = err_q;
        state_d = StIdle;
      end
      StScFail: begin
        dhit    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      load_q   <= '0;
      write_q  <= 1'b0;
      atomic_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      load_q   <= load_d;
      write_q  <= write_d;
      atomic_q <= atomic_d;
      err_q    <= err_d;
    end
  end

  // Reservation updates on successful completion; snoop is applied last so it wins.
  always_comb begin
    link_d = link_q;
    if ((state_q == StResp) && !err_q) begin
      if (write_q && (atomic_q || (link_q.addr == addr_q))) link_d.valid = 1'b0;
      if (!write_q && atomic_q) link_d = '{valid: 1'b1, addr: addr_q};
    end
    if (snoopwen && (snoopaddr[31:2] == link_d.addr)) link_d.valid = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) link_q <= '0;
    else     link_q <= link_d;
  end

endmodule
